// File: rtl/spi_read_ctrl_if.sv
// Host-side bus of the SPI flash read controller: request/address/length in,
// status and received bytes out.
interface spi_read_ctrl_if;
  logic        req;
  logic [23:0] addr;
  logic [7:0]  len;
  logic        busy;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        done;

  modport master (output req, addr, len, input busy, rdata, rvalid, done);
  modport slave  (input req, addr, len, output busy, rdata, rvalid, done);
endinterface

// File: rtl/spi_read_ctrl.sv
// SPI mode-0 flash read controller: sends {0x03, addr} then streams len bytes
// (0 means 256) back to the host, one rvalid pulse per byte and a done pulse at the end.
module spi_read_ctrl #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_read_ctrl_if.slave host,
  output logic           SCK,
  output logic           CSbar,
  output logic           MOSI,
  input  logic           MISO
);
  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [7:0] GapLast = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StCmd, StData, StHold, StGap} state_e;

  state_e      state_q, state_d;
  logic [1:0]  rst_sync_q;
  logic [7:0]  div_q, div_d;
  logic [11:0] bit_q, bit_d;
  logic [11:0] total_q, total_d;
  logic [31:0] cmd_q, cmd_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        sck_q, sck_d;
  logic        csb_q, csb_d;
  logic        mosi_q, mosi_d;
  logic        div_last;
  logic [31:0] frame;

  assign div_last = (div_q == DivLast);
  assign frame    = {8'h03, host.addr};

  // Reset release is synchronised; the FSM may not accept a request until it propagates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    total_d  = total_q;
    cmd_d    = cmd_q;
    sh_d     = sh_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    sck_d    = sck_q;
    csb_d    = csb_q;
    mosi_d   = mosi_q;
    case (state_q)
      StIdle: begin
        div_d = 8'd0;
        bit_d = 12'd0;
        if (host.req && rst_sync_q[1]) begin
          state_d = StSetup;
          busy_d  = 1'b1;
          csb_d   = 1'b0;
          cmd_d   = frame;
          mosi_d  = frame[31];
          total_d = (host.len == 8'd0) ? 12'h800 : {1'b0, host.len, 3'b000};
        end
      end
      StSetup: begin
        div_d = div_q + 8'd1;
        if (div_last) begin
          div_d   = 8'd0;
          sck_d   = 1'b1;
          state_d = StCmd;
        end
      end
      StCmd: begin
        div_d = div_q + 8'd1;
        if (div_last) begin
          div_d = 8'd0;
          sck_d = ~sck_q;
          if (sck_q) begin
            // Falling edge: present the next frame bit, or park MOSI low after bit 0.
            bit_d  = bit_q + 12'd1;
            cmd_d  = {cmd_q[30:0], 1'b0};
            mosi_d = cmd_q[30];
            if (bit_q == 12'd31) begin
              mosi_d  = 1'b0;
              bit_d   = 12'd0;
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        div_d = div_q + 8'd1;
        if (div_last) begin
          div_d = 8'd0;
          sck_d = ~sck_q;
          if (!sck_q) begin
            sh_d  = {sh_q[6:0], MISO};
            bit_d = bit_q + 12'd1;
            if (bit_q[2:0] == 3'd7) begin
              rdata_d  = {sh_q[6:0], MISO};
              rvalid_d = 1'b1;
            end
          end else if (bit_q == total_q) begin
            bit_d   = 12'd0;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        div_d = div_q + 8'd1;
        if (div_last) begin
          div_d   = 8'd0;
          csb_d   = 1'b1;
          done_d  = 1'b1;
          state_d = StGap;
        end
      end
      StGap: begin
        div_d = div_q + 8'd1;
        if (div_q == GapLast) begin
          div_d   = 8'd0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        div_d   = 8'd0;
        bit_d   = 12'd0;
        busy_d  = 1'b0;
        sck_d   = 1'b0;
        csb_d   = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      div_q    <= 8'd0;
      bit_q    <= 12'd0;
      total_q  <= 12'd0;
      cmd_q    <= 32'd0;
      sh_q     <= 8'd0;
      rdata_q  <= 8'd0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      sck_q    <= 1'b0;
      csb_q    <= 1'b1;
      mosi_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      total_q  <= total_d;
      cmd_q    <= cmd_d;
      sh_q     <= sh_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      sck_q    <= sck_d;
      csb_q    <= csb_d;
      mosi_q   <= mosi_d;
    end
  end

  assign host.busy   = busy_q;
  assign host.rdata  = rdata_q;
  assign host.rvalid = rvalid_q;
  assign host.done   = done_q;
  assign SCK         = sck_q;
  assign CSbar       = csb_q;
  assign MOSI        = mosi_q;
endmodule

// File: tb/tb_spi_read_ctrl.sv
// Bench for spi_read_ctrl: two instances (CLK_DIV 2 and 5) talk to a behavioural SPI flash
// whose contents are random; transfers are checked against frame/byte expectations.
module tb_spi_read_ctrl;
  logic clk, rst_n;
  logic sck0, csb0, mosi0, sck1, csb1, mosi1;
  logic [1:0] miso_v;
  logic [1:0] sck_v, csb_v, mosi_v, busy_v, rvalid_v, done_v;
  logic [1:0][7:0] rdata_v;

  spi_read_ctrl_if bus0 ();
  spi_read_ctrl_if bus1 ();

  spi_read_ctrl #(.CLK_DIV(2), .CS_GAP(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .host(bus0),
    .SCK(sck0), .CSbar(csb0), .MOSI(mosi0), .MISO(miso_v[0])
  );
  spi_read_ctrl #(.CLK_DIV(5), .CS_GAP(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .host(bus1),
    .SCK(sck1), .CSbar(csb1), .MOSI(mosi1), .MISO(miso_v[1])
  );

  assign sck_v    = {sck1, sck0};
  assign csb_v    = {csb1, csb0};
  assign mosi_v   = {mosi1, mosi0};
  assign busy_v   = {bus1.busy, bus0.busy};
  assign rvalid_v = {bus1.rvalid, bus0.rvalid};
  assign done_v   = {bus1.done, bus0.done};
  assign rdata_v  = {bus1.rdata, bus0.rdata};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0]  mem [256];
  int          nbits [2];
  int          vectors = 0;
  int          miscompares = 0;

  // Flash model and observation state, written only by the monitor below.
  logic [31:0] frame_m [2];
  logic [7:0]  rx [2][512];
  int rise_n [2], fall_n [2], rx_cnt [2], done_cnt [2], acc_cnt [2], cs_rise [2];
  int ph_len [2], bad_phase [2], mosi_at_rise [2], overlap [2], hi_run [2];
  int last_gap [2], min_gap [2];
  logic [1:0] sck_p, csb_p, mosi_p, busy_p;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rise_n[i] = 0; fall_n[i] = 0; rx_cnt[i] = 0; done_cnt[i] = 0; acc_cnt[i] = 0;
      cs_rise[i] = 0; ph_len[i] = 0; bad_phase[i] = 0; mosi_at_rise[i] = 0; overlap[i] = 0;
      hi_run[i] = 0; last_gap[i] = 0; min_gap[i] = 100000; frame_m[i] = 32'd0;
    end
    sck_p = 2'b00; csb_p = 2'b11; mosi_p = 2'b00; busy_p = 2'b00; miso_v = 2'b00;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int j;
      int div;
      div = (i == 0) ? 2 : 5;
      if (rvalid_v[i]) begin
        rx[i][rx_cnt[i] % 512] = rdata_v[i];
        rx_cnt[i]++;
      end
      if (done_v[i]) done_cnt[i]++;
      if (done_v[i] && rvalid_v[i]) overlap[i]++;
      if (busy_v[i] && !busy_p[i]) acc_cnt[i]++;
      if (csb_v[i] && !csb_p[i]) cs_rise[i]++;
      if (!csb_v[i] && csb_p[i]) begin
        last_gap[i] = hi_run[i];
        if (hi_run[i] < min_gap[i]) min_gap[i] = hi_run[i];
        rise_n[i] = 0; fall_n[i] = 0; frame_m[i] = 32'd0; ph_len[i] = 0;
      end
      hi_run[i] = csb_v[i] ? hi_run[i] + 1 : 0;
      if (!csb_v[i] && rst_n) begin
        if (sck_v[i] != sck_p[i]) begin
          if (ph_len[i] != div) bad_phase[i]++;
          ph_len[i] = 1;
          if (sck_v[i]) begin
            rise_n[i]++;
            if (rise_n[i] <= 32) frame_m[i] = {frame_m[i][30:0], mosi_v[i]};
            if (mosi_v[i] != mosi_p[i]) mosi_at_rise[i]++;
          end else begin
            fall_n[i]++;
          end
        end else begin
          ph_len[i]++;
        end
        // Flash shifts data out on SCK falls after the 32-bit command; noise otherwise.
        j = fall_n[i] - 32;
        if (fall_n[i] >= 32 && j < nbits[i])
          miso_v[i] = mem[8'(frame_m[i][7:0] + 8'(j / 8))][7 - (j % 8)];
        else
          miso_v[i] = 1'($urandom);
      end else begin
        miso_v[i] = 1'($urandom);
      end
      sck_p[i] = sck_v[i]; csb_p[i] = csb_v[i]; mosi_p[i] = mosi_v[i]; busy_p[i] = busy_v[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic r, input logic [23:0] a, input logic [7:0] l);
    if (i == 0) begin
      bus0.req = r; bus0.addr = a; bus0.len = l;
    end else begin
      bus1.req = r; bus1.addr = a; bus1.len = l;
    end
  endtask

  task automatic run(input int i, input logic [23:0] a, input logic [7:0] l);
    @(negedge clk);
    nbits[i] = (l == 8'd0) ? 2048 : 8 * int'(l);
    set_req(i, 1'b1, a, l);
    for (int k = 0; k < 20 && !busy_v[i]; k++) @(negedge clk);
    chk("accept", 32'(busy_v[i]), 32'd1);
    set_req(i, 1'b0, a, l);
    for (int k = 0; k < 30000 && busy_v[i]; k++) @(negedge clk);
    chk("return_idle", 32'(busy_v[i]), 32'd0);
  endtask

  task automatic txn(input int i, input logic [23:0] a, input logic [7:0] l);
    int b_rx, b_done, b_cs, nby;
    nby    = (l == 8'd0) ? 256 : int'(l);
    b_rx   = rx_cnt[i];
    b_done = done_cnt[i];
    b_cs   = cs_rise[i];
    run(i, a, l);
    chk("mosi_frame", frame_m[i], {8'h03, a});
    chk("sck_rises", 32'(rise_n[i]), 32'(32 + 8 * nby));
    chk("rvalid_count", 32'(rx_cnt[i] - b_rx), 32'(nby));
    chk("done_count", 32'(done_cnt[i] - b_done), 32'd1);
    chk("csbar_rises", 32'(cs_rise[i] - b_cs), 32'd1);
    for (int k = 0; k < nby; k++)
      chk("rdata", 32'(rx[i][(b_rx + k) % 512]), 32'(mem[8'(int'(a[7:0]) + k)]));
  endtask

  initial begin
    int b_rx, b_done, b_acc;
    set_req(0, 1'b0, 24'd0, 8'd0);
    set_req(1, 1'b0, 24'd0, 8'd0);
    nbits[0] = 0; nbits[1] = 0;
    for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
    mem[16] = 8'hA5;

    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_sck", 32'(sck0), 32'd0);
    chk("rst_csbar", 32'(csb0), 32'd1);
    chk("rst_mosi", 32'(mosi0), 32'd0);
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_rvalid", 32'(bus0.rvalid), 32'd0);
    chk("rst_done", 32'(bus0.done), 32'd0);
    chk("rst_rdata", 32'(bus0.rdata), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    txn(0, 24'h000010, 8'd1);
    txn(0, 24'h000000, 8'd0);
    for (int k = 0; k < 3; k++) txn(k % 2, 24'($urandom), 8'($urandom_range(1, 4)));

    // req held high: three back-to-back reads, then release before a fourth.
    b_rx = rx_cnt[0]; b_done = done_cnt[0]; b_acc = acc_cnt[0];
    @(negedge clk);
    nbits[0] = 8;
    set_req(0, 1'b1, 24'h0000C3, 8'd1);
    for (int k = 0; k < 3000 && (done_cnt[0] - b_done) < 3; k++) @(negedge clk);
    set_req(0, 1'b0, 24'h0000C3, 8'd1);
    for (int k = 0; k < 300 && busy_v[0]; k++) @(negedge clk);
    chk("b2b_idle", 32'(busy_v[0]), 32'd0);
    chk("b2b_accepts", 32'(acc_cnt[0] - b_acc), 32'd3);
    chk("b2b_dones", 32'(done_cnt[0] - b_done), 32'd3);
    chk("b2b_rvalids", 32'(rx_cnt[0] - b_rx), 32'd3);
    chk("b2b_gap", 32'(last_gap[0] >= 4), 32'd1);
    for (int k = 0; k < 3; k++)
      chk("b2b_rdata", 32'(rx[0][(b_rx + k) % 512]), 32'(mem[8'hC3]));

    // Reset in the middle of byte 3 of an 8-byte read.
    b_rx = rx_cnt[0]; b_done = done_cnt[0];
    @(negedge clk);
    nbits[0] = 64;
    set_req(0, 1'b1, 24'h000040, 8'd8);
    @(negedge clk);
    set_req(0, 1'b0, 24'h000040, 8'd8);
    for (int k = 0; k < 2000 && (rx_cnt[0] - b_rx) < 2; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_csbar", 32'(csb0), 32'd1);
    chk("abort_sck", 32'(sck0), 32'd0);
    chk("abort_busy", 32'(bus0.busy), 32'd0);
    chk("abort_rdata", 32'(bus0.rdata), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt[0] - b_done), 32'd0);
    txn(0, 24'h000080, 8'd2);

    txn(1, 24'h123456, 8'd2);
    txn(0, 24'($urandom), 8'd3);

    chk("phase_div2", 32'(bad_phase[0]), 32'd0);
    chk("phase_div5", 32'(bad_phase[1]), 32'd0);
    chk("mosi_rise_div2", 32'(mosi_at_rise[0]), 32'd0);
    chk("mosi_rise_div5", 32'(mosi_at_rise[1]), 32'd0);
    chk("overlap0", 32'(overlap[0]), 32'd0);
    chk("overlap1", 32'(overlap[1]), 32'd0);
    chk("min_gap", 32'(min_gap[0] >= 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
